// File: rtl/clk_rst_pkg.sv
// Shared definitions for the reset sequencer.
// Contents:
//   - seq_state_t   : sequencer state encoding (HOLD, PERIPH, RUN)
//   - DEF_CLK_HZ    : default input clock frequency
//   - DEF_TICK_HZ   : default timebase tick rate
//   - DEF_TICK_DIV  : clock cycles per tick for the defaults
//   - SOFT_CNT_W    : width of the soft-reset entry counter
//   - sat_inc_soft  : saturating increment for the soft-reset counter
package clk_rst_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        PERIPH = 2'd1,
        RUN    = 2'd2
    } seq_state_t;

    localparam int DEF_CLK_HZ   = 100000000;
    localparam int DEF_TICK_HZ  = 1000000;
    localparam int DEF_TICK_DIV = DEF_CLK_HZ / DEF_TICK_HZ;

    localparam int SOFT_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SOFT_CNT_W-1:0] sat_inc_soft(input logic [SOFT_CNT_W-1:0] v);
        logic [SOFT_CNT_W-1:0] r;
        if (v == {SOFT_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(SOFT_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_rst_seq_tick_gen.sv
// Timebase tick generator.
// Emits a registered one-cycle pulse on tick every TICK_DIV enabled cycles.
// Ports:
//   clkin   in  clock
//   reset_n in  synchronous active-low reset
//   en      in  enable; the divider is cleared and tick held low while en=0
//   tick    out one-cycle pulse, registered
module tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clkin,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    import clk_rst_pkg::*;

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("tick_gen: TICK_DIV must be at least 2");
    end

    logic [TW-1:0] tick_cnt;

    // Divider counter and registered tick pulse; disabling clears both so a
    // tick that was due on the same edge as the disable is dropped.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            tick_cnt <= {TW{1'b0}};
            tick     <= 1'b0;
        end else if (!en) begin
            tick_cnt <= {TW{1'b0}};
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= {TW{1'b0}};
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
            tick     <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Staged reset sequencer for the peripheral and core domains.
// After reset_n (or a soft-reset request) releases, periph_rst_n stays low
// for HOLD_CYCLES cycles, then core_rst_n stays low for STAGGER_CYCLES more.
// Once both are released the block is in RUN: ready is high and a 1 us
// timebase tick is produced.
// Ports:
//   clkin         in   clock (PLL output)
//   reset_n       in   synchronous active-low reset
//   soft_rst_req  in   level request to re-run the reset sequence
//   periph_rst_n  out  peripheral-domain reset, active-low, registered
//   core_rst_n    out  core-domain reset, active-low, registered
//   ready         out  high while in RUN, registered
//   tick          out  one-cycle pulse every TICK_DIV cycles in RUN
//   soft_rst_cnt  out  saturating count of soft-reset entries
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int TICK_HZ        = DEF_TICK_HZ,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 64
) (
    input  logic                  clkin,
    input  logic                  reset_n,
    input  logic                  soft_rst_req,
    output logic                  periph_rst_n,
    output logic                  core_rst_n,
    output logic                  ready,
    output logic                  tick,
    output logic [SOFT_CNT_W-1:0] soft_rst_cnt
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_MAX  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    // A one-cycle hold/stagger still needs a 1-bit counter.
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("clk_rst_seq: HOLD_CYCLES must be at least 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("clk_rst_seq: STAGGER_CYCLES must be at least 1");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("clk_rst_seq: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
        $error("clk_rst_seq: CLK_HZ must be an integer multiple of TICK_HZ");
    end

    seq_state_t            state_r;
    seq_state_t            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [SOFT_CNT_W-1:0] soft_cnt_r;
    logic [SOFT_CNT_W-1:0] soft_cnt_nxt_s;
    logic                  periph_rst_n_r;
    logic                  core_rst_n_r;
    logic                  ready_r;
    logic                  tick_en_s;

    // State register, phase counter and output flops; outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state_r        <= HOLD;
            cnt_r          <= {CNT_W{1'b0}};
            soft_cnt_r     <= {SOFT_CNT_W{1'b0}};
            periph_rst_n_r <= 1'b0;
            core_rst_n_r   <= 1'b0;
            ready_r        <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            soft_cnt_r     <= soft_cnt_nxt_s;
            periph_rst_n_r <= (state_nxt_s != HOLD);
            core_rst_n_r   <= (state_nxt_s == RUN);
            ready_r        <= (state_nxt_s == RUN);
        end
    end

    // Next-state logic. A request in HOLD only pins the counter at zero;
    // leaving PERIPH/RUN for HOLD is what counts as a soft-reset entry, so a
    // long request is counted once.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        soft_cnt_nxt_s = soft_cnt_r;
        case (state_r)
            HOLD: begin
                if (soft_rst_req) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = PERIPH;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            PERIPH: begin
                if (soft_rst_req) begin
                    state_nxt_s    = HOLD;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    soft_cnt_nxt_s = sat_inc_soft(soft_cnt_r);
                end else if (cnt_r == STAGGER_LAST) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_nxt_s    = HOLD;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    soft_cnt_nxt_s = sat_inc_soft(soft_cnt_r);
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = HOLD;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Gating with the request suppresses a tick that would land on the same
    // edge the sequencer drops out of RUN.
    assign tick_en_s = (state_r == RUN) & ~soft_rst_req;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clkin   (clkin),
        .reset_n (reset_n),
        .en      (tick_en_s),
        .tick    (tick)
    );

    assign periph_rst_n = periph_rst_n_r;
    assign core_rst_n   = core_rst_n_r;
    assign ready        = ready_r;
    assign soft_rst_cnt = soft_cnt_r;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq with small parameters
// (HOLD=8, STAGGER=4, TICK_DIV=5). Expected outputs come from an
// edge-counting reference: "rel" is the number of consecutive edges with
// reset_n=1 and no soft request, from which every output follows directly.
module tb_clk_rst_seq;

    localparam int H   = 8;
    localparam int S   = 4;
    localparam int DIV = 5;

    typedef struct packed {
        logic       periph;
        logic       core;
        logic       rdy;
        logic       tck;
        logic [7:0] scnt;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       soft_rst_req;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic       tick;
    logic [7:0] soft_rst_cnt;

    int tests_run;
    int tests_failed;

    int   m_rel;
    int   m_scnt;
    exp_t exp_q[$];

    clk_rst_seq #(
        .CLK_HZ         (5),
        .TICK_HZ        (1),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S)
    ) dut (
        .clkin        (clk),
        .reset_n      (reset_n),
        .soft_rst_req (soft_rst_req),
        .periph_rst_n (periph_rst_n),
        .core_rst_n   (core_rst_n),
        .ready        (ready),
        .tick         (tick),
        .soft_rst_cnt (soft_rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, push the reference result, then compare
    // after the edge.
    task automatic step(input logic rn, input logic req);
        exp_t e;
        exp_t g;
        reset_n      = rn;
        soft_rst_req = req;
        if (!rn) begin
            m_rel  = 0;
            m_scnt = 0;
        end else if (req) begin
            if (m_rel >= H && m_scnt < 255) m_scnt++;
            m_rel = 0;
        end else begin
            m_rel++;
        end
        e.periph = (m_rel >= H);
        e.core   = (m_rel >= H + S);
        e.rdy    = (m_rel >= H + S);
        e.tck    = (m_rel > H + S) && (((m_rel - H - S) % DIV) == 0);
        e.scnt   = m_scnt[7:0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g.periph = periph_rst_n;
        g.core   = core_rst_n;
        g.rdy    = ready;
        g.tck    = tick;
        g.scnt   = soft_rst_cnt;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("periph_rst_n", {31'd0, g.periph}, {31'd0, e.periph});
            check_eq("core_rst_n",   {31'd0, g.core},   {31'd0, e.core});
            check_eq("ready",        {31'd0, g.rdy},    {31'd0, e.rdy});
            check_eq("tick",         {31'd0, g.tck},    {31'd0, e.tck});
            check_eq("soft_rst_cnt", {24'd0, g.scnt},   {24'd0, e.scnt});
        end
    endtask

    task automatic run(input int n, input logic req);
        for (int i = 0; i < n; i++) step(1'b1, req);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_rel        = 0;
        m_scnt       = 0;
        reset_n      = 1'b0;
        soft_rst_req = 1'b0;

        // Power-on: 3 reset cycles, then edges 1..29 normal, request on edge 30.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        run(29, 1'b0);
        step(1'b1, 1'b1);
        run(16, 1'b0);
        check_eq("soft_cnt_after_one", {24'd0, soft_rst_cnt}, 32'd1);

        // Held request for 20 cycles while in RUN.
        run(20, 1'b1);
        run(20, 1'b0);
        check_eq("soft_cnt_after_held", {24'd0, soft_rst_cnt}, 32'd2);

        // Reset asserted on edge 10 of a fresh sequence (mid-PERIPH).
        step(1'b1, 1'b1);
        run(9, 1'b0);
        step(1'b0, 1'b0);
        check_eq("mid_periph_reset_periph", {31'd0, periph_rst_n}, 32'd0);
        check_eq("mid_periph_reset_cnt", {24'd0, soft_rst_cnt}, 32'd0);
        run(20, 1'b0);

        // Reset wins over a simultaneous soft request.
        step(1'b0, 1'b1);
        // Tick collision: request on the edge where tick_cnt==4 (edge 17).
        run(16, 1'b0);
        step(1'b1, 1'b1);
        check_eq("collision_tick", {31'd0, tick}, 32'd0);
        run(20, 1'b0);

        // Saturation: 300 separate pulses, each issued in RUN.
        for (int p = 0; p < 300; p++) begin
            run(H + S, 1'b0);
            step(1'b1, 1'b1);
        end
        check_eq("saturated_cnt", {24'd0, soft_rst_cnt}, 32'd255);
        run(H + S + 2, 1'b0);

        // Final reset clears the saturated counter.
        step(1'b0, 1'b0);
        check_eq("final_reset_cnt", {24'd0, soft_rst_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
